// File: rtl/blink_pkg.sv
// Shared state encoding, default timing constants and helpers for the pulse blinker.
package blink_pkg;

  localparam int unsigned ON_CYCLES_DEF  = 100000;
  localparam int unsigned GAP_CYCLES_DEF = 50000;
  localparam int unsigned MAX_PEND_DEF   = 15;
  localparam int unsigned PEND_W_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } blink_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter that flags the last cycle of a phase; holds at zero once expired.
module blink_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/pulse_blinker.sv
// Stretches one-cycle event strobes into fixed ON/GAP blinks, queueing events that
// arrive while a blink is in progress.
module pulse_blinker
  import blink_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = ON_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int unsigned MAX_PEND   = MAX_PEND_DEF,
  parameter int unsigned PEND_W     = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int unsigned TMR_W = $clog2(max_u(ON_CYCLES, GAP_CYCLES) + 1);

  blink_state_e      r_state, w_state_nxt;
  logic [PEND_W-1:0] r_pend, w_pend_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              r_level, r_busy;
  logic              w_load;
  logic [TMR_W-1:0]  w_load_val;
  logic              w_done;
  logic              w_room;

  blink_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done_c   (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_nxt;
      r_level <= (w_state_nxt == ON);
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign w_room = (r_pend < PEND_W'(MAX_PEND));

  // Timer is reloaded on every state entry; loading zero on IDLE keeps it parked.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_ovf_nxt   = r_ovf;
    w_load      = 1'b0;
    w_load_val  = '0;
    if (clear) begin
      w_state_nxt = IDLE;
      w_pend_nxt  = '0;
      w_ovf_nxt   = 1'b0;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (pulse_in) begin
            w_state_nxt = ON;
            w_load      = 1'b1;
            w_load_val  = TMR_W'(ON_CYCLES - 1);
          end
        end
        ON: begin
          if (pulse_in) begin
            if (w_room) w_pend_nxt = r_pend + PEND_W'(1);
            else        w_ovf_nxt  = 1'b1;
          end
          if (w_done) begin
            w_state_nxt = GAP;
            w_load      = 1'b1;
            w_load_val  = TMR_W'(GAP_CYCLES - 1);
          end
        end
        GAP: begin
          if (w_done) begin
            w_load = 1'b1;
            if ((r_pend != '0) || pulse_in) begin
              // A strobe on the final gap cycle replaces the dequeue, so no overflow here.
              w_state_nxt = ON;
              w_load_val  = TMR_W'(ON_CYCLES - 1);
              if ((r_pend != '0) && !pulse_in) w_pend_nxt = r_pend - PEND_W'(1);
            end else begin
              w_state_nxt = IDLE;
            end
          end else if (pulse_in) begin
            if (w_room) w_pend_nxt = r_pend + PEND_W'(1);
            else        w_ovf_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_pend_nxt  = '0;
          w_load      = 1'b1;
        end
      endcase
    end
  end

  assign level_out = r_level;
  assign busy      = r_busy;
  assign pend_cnt  = r_pend;
  assign overflow  = r_ovf;

endmodule
